// File: rtl/lap_timer.sv
// lap_timer: BCD SS.hh stopwatch with lap capture, clear and synchronised raw button inputs.
// Optional LAP_TIMER_SATURATE_EN: hold at 99.99 and stop instead of wrapping.
module lap_timer #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int TICK_HZ     = 100
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start_stop,
  input  logic        i_lap,
  input  logic        i_clear,
  output logic [15:0] o_data_out,
  output logic        o_running,
  output logic        o_lap_active,
  output logic        o_overflow
);
  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  typedef enum logic [1:0] {IDLE, RUN, STOP, LAP_RUN} state_t;
  state_t          r_state, w_next;
  logic [2:0]      r_sync1, r_sync2, r_prev, w_pulse;
  logic [PW-1:0]   r_presc;
  logic [15:0]     r_count, r_lap, w_inc;
  logic            r_ovf, w_counting, w_tick, w_max, w_sat, w_cap, w_c;
  logic            w_clr, w_ss, w_lp;
  // bit order {clear, start_stop, lap}
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= {i_clear, i_start_stop, i_lap};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  assign w_pulse    = r_sync2 & ~r_prev;
  assign w_clr      = w_pulse[2];
  assign w_ss       = w_pulse[1];
  assign w_lp       = w_pulse[0];
  assign w_counting = (r_state == RUN) || (r_state == LAP_RUN);
  assign w_tick     = w_counting && (r_presc == PW'(DIV - 1));
  assign w_max      = (r_count == 16'h9999);
`ifdef LAP_TIMER_SATURATE_EN
  assign w_sat = w_tick & w_max;
`else
  assign w_sat = 1'b0;
`endif
  assign w_cap = w_counting & w_lp & ~w_ss & ~w_clr;
  always_comb begin
    w_inc = r_count;
    w_c   = 1'b1;
    for (int k = 0; k < 4; k++)
      if (w_c) begin
        if (w_inc[4*k +: 4] == 4'd9) w_inc[4*k +: 4] = 4'd0;
        else begin
          w_inc[4*k +: 4] = w_inc[4*k +: 4] + 4'd1;
          w_c = 1'b0;
        end
      end
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_ss ? RUN : IDLE;
      RUN:     w_next = w_ss ? STOP : (w_lp ? LAP_RUN : RUN);
      LAP_RUN: w_next = w_ss ? STOP : LAP_RUN;
      STOP:    w_next = w_ss ? RUN : (w_lp ? IDLE : STOP);
      default: w_next = IDLE;
    endcase
    if (w_sat) w_next = STOP;
    if (w_clr) w_next = IDLE;
  end
  // entering (or staying in) IDLE zeroes the whole datapath
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_presc <= '0;
      r_count <= '0;
      r_lap   <= '0;
      r_ovf   <= 1'b0;
    end else if (w_next == IDLE) begin
      r_presc <= '0;
      r_count <= '0;
      r_lap   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_counting) r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick && !w_sat) r_count <= w_inc;
      if (w_tick && w_max) r_ovf <= 1'b1;
      if (w_cap) r_lap <= r_count;
    end
  always_comb begin
    o_data_out   = (r_state == LAP_RUN) ? r_lap : r_count;
    o_running    = w_counting;
    o_lap_active = (r_state == LAP_RUN);
    o_overflow   = r_ovf;
  end
endmodule

// File: tb/tb_lap_timer.sv
// tb_lap_timer: directed checks of lap_timer at DIV=10 (main) and DIV=2 (fast wrap/carry run).
module tb_lap_timer;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [2:0]  btn = 3'b000, btn2 = 3'b000;
  logic [15:0] d, fd;
  logic        run, lap_a, ov, frun, flap, fov;
  int          checks = 0, errors = 0;
  localparam logic [2:0] CLR = 3'b100, SS = 3'b010, LAP = 3'b001;

  lap_timer #(.CLK_FREQ_HZ(1000), .TICK_HZ(100)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start_stop(btn[1]), .i_lap(btn[0]), .i_clear(btn[2]),
    .o_data_out(d), .o_running(run), .o_lap_active(lap_a), .o_overflow(ov));

  lap_timer #(.CLK_FREQ_HZ(200), .TICK_HZ(100)) u_fast (
    .i_clk(clk), .i_rst_n(rst_n), .i_start_stop(btn2[1]), .i_lap(btn2[0]), .i_clear(btn2[2]),
    .o_data_out(fd), .o_running(frun), .o_lap_active(flap), .o_overflow(fov));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // idle gap, then hold the button so it acts on the 6th edge after the call
  task automatic press(input logic [2:0] m, input bit fast);
    step(3);
    if (fast) btn2 = btn2 | m; else btn = btn | m;
    step(3);
    if (fast) btn2 = btn2 & ~m; else btn = btn & ~m;
  endtask

  initial begin
    step(2);
    chk("rst_data", d, 16'h0000);
    chk("rst_run", {15'b0, run}, 16'd0);
    chk("rst_lap", {15'b0, lap_a}, 16'd0);
    chk("rst_ovf", {15'b0, ov}, 16'd0);
    chk("rst_fast", fd, 16'h0000);
    rst_n = 1'b1;
    press(SS, 0);
    chk("start_run", {15'b0, run}, 16'd1);
    step(249);
    press(SS, 0);
    chk("stop_data", d, 16'h0025);
    chk("stop_run", {15'b0, run}, 16'd0);
    step(100);
    chk("stop_hold", d, 16'h0025);
    press(SS, 0);
    chk("resume_run", {15'b0, run}, 16'd1);
    step(4);
    chk("resume_partial_pre", d, 16'h0025);
    step(1);
    chk("resume_partial_tick", d, 16'h0026);
    step(159);
    press(LAP, 0);
    chk("lap_data", d, 16'h0042);
    chk("lap_active", {15'b0, lap_a}, 16'd1);
    chk("lap_running", {15'b0, run}, 16'd1);
    step(20);
    chk("lap_frozen", d, 16'h0042);
    press(LAP, 0);
    chk("lap_recapture", d, 16'h0045);
    step(94);
    press(SS, 0);
    chk("lap_stop_live", d, 16'h0055);
    chk("lap_stop_active", {15'b0, lap_a}, 16'd0);
    chk("lap_stop_run", {15'b0, run}, 16'd0);
    press(SS, 0);
    press(CLR | SS, 0);
    chk("clr_data", d, 16'h0000);
    chk("clr_run", {15'b0, run}, 16'd0);
    chk("clr_ovf", {15'b0, ov}, 16'd0);
    press(SS, 0);
    step(30);
    press(SS, 0);
    chk("stop2_data", d, 16'h0003);
    press(LAP, 0);
    chk("stop_lap_idle", d, 16'h0000);
    chk("stop_lap_run", {15'b0, run}, 16'd0);
    press(SS, 0);
    step(3170);
    chk("pre_rst", d, 16'h0317);
    rst_n = 1'b0;
    #1;
    chk("async_rst_data", d, 16'h0000);
    chk("async_rst_run", {15'b0, run}, 16'd0);
    rst_n = 1'b1;
    btn[1] = 1'b1;
    step(3);
    chk("held_start", {15'b0, run}, 16'd1);
    chk("held_zero", d, 16'h0000);
    step(47);
    chk("held_count", d, 16'h0004);
    chk("held_run", {15'b0, run}, 16'd1);
    btn[1] = 1'b0;
    step(5);
    chk("release_run", {15'b0, run}, 16'd1);
    press(SS, 1);
    step(198);
    chk("f_0099", fd, 16'h0099);
    step(2);
    chk("f_0100", fd, 16'h0100);
    step(1798);
    chk("f_0999", fd, 16'h0999);
    step(2);
    chk("f_1000", fd, 16'h1000);
    step(17998);
    chk("f_9999", fd, 16'h9999);
    chk("f_pre_ovf", {15'b0, fov}, 16'd0);
    step(2);
    chk("f_wrap_ovf", {15'b0, fov}, 16'd1);
`ifdef LAP_TIMER_SATURATE_EN
    chk("f_sat_data", fd, 16'h9999);
    chk("f_sat_run", {15'b0, frun}, 16'd0);
    press(SS, 1);
    chk("f_sat_rerun", {15'b0, frun}, 16'd1);
    step(2);
    chk("f_sat2_data", fd, 16'h9999);
    chk("f_sat2_ovf", {15'b0, fov}, 16'd1);
    chk("f_sat2_run", {15'b0, frun}, 16'd0);
`else
    chk("f_wrap_data", fd, 16'h0000);
    chk("f_wrap_run", {15'b0, frun}, 16'd1);
    step(2);
    chk("f_after_wrap", fd, 16'h0001);
    chk("f_ovf_sticky", {15'b0, fov}, 16'd1);
`endif
    press(CLR, 1);
    chk("f_clr_data", fd, 16'h0000);
    chk("f_clr_ovf", {15'b0, fov}, 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lap_timer.md
Name: lap_timer

Overview:
- BCD stopwatch core with start/stop, lap (split) capture and clear.
- Drives the 16-bit packed digit bus into the seven-segment display controller; display format SS.hh (00.00–99.99), decimal point on digit 2 set by the display side.
- Also synchronises and edge-detects the raw button and switch levels, so it connects directly to board pins.

Parameters:
- CLK_FREQ_HZ, 100000000, input clock frequency.
- TICK_HZ, 100, count resolution (hundredths of a second).
- DIV (localparam) = CLK_FREQ_HZ/TICK_HZ; must be ≥ 2.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- start_stop  input  1  raw level from button; acted on at rising edge
- lap  input  1  raw level; acted on at rising edge
- clear  input  1  raw level; acted on at rising edge
- data_out  output  16  packed BCD {d3,d2,d1,d0}; d3d2 = seconds, d1d0 = hundredths
- running  output  1  high in RUN or LAP_RUN
- lap_active  output  1  high in LAP_RUN (display frozen)
- overflow  output  1  sticky; set on 99.99 wrap

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; count, lap_reg, prescaler, sync/edge flops = 0.
  - data_out = 0x0000; running, lap_active, overflow = 0.
  - Reset asserted mid-run returns to these values immediately, without waiting for a clock edge.
- Input path: each input passes through a 2-FF synchroniser and a previous-value register; pulse = sync2 & ~prev.
  - An input that goes high before clock edge 1 acts at edge 3 (state, count and data_out all update at edge 3).
  - A held level produces one pulse only.
- Prescaler:
  - Counts 0..DIV-1 only in RUN/LAP_RUN; tick asserts when it equals DIV-1, then it returns to 0.
  - Held (not cleared) in STOP, so a resume continues the partial period.
  - Zeroed on entry to IDLE.
- Count: four BCD digits, each 0–9. On a tick, d0 increments; a digit that passes 9 returns to 0 and carries into the next digit.
  - 0x0099 → 0x0100; 0x0999 → 0x1000.
  - Wrap at 0x9999: see Optional Feature.
- States and transitions (pulses are evaluated in priority order clear > start_stop > lap; lower-priority pulses in the same cycle are discarded):
  - IDLE:
    - start_stop → RUN.
    - lap and clear have no effect.
  - RUN:
    - start_stop → STOP.
    - lap → LAP_RUN and lap_reg ← count (the value before any same-cycle tick increment).
  - LAP_RUN:
    - Counting continues.
    - lap → re-capture lap_reg, stay in LAP_RUN.
    - start_stop → STOP; display returns to the live count.
  - STOP:
    - start_stop → RUN.
    - lap → IDLE (count, prescaler, lap_reg, overflow zeroed).
  - Any state: clear → IDLE (same zeroing as above).
- Outputs:
  - data_out = lap_reg in LAP_RUN, otherwise count. It is a mux of registered values with no extra latency.
  - running and lap_active are decoded from the state register.
- overflow is cleared only by reset or entry to IDLE.

Optional Feature:
- Macro: LAP_TIMER_SATURATE_EN.
- Defined: on a tick at 0x9999, count holds at 0x9999, state → STOP (running = 0), overflow = 1.
  - A later start_stop re-enters RUN, and the next tick sets overflow again with count still 0x9999.
- Undefined: a tick at 0x9999 wraps count to 0x0000, overflow = 1, and counting continues.

Test Plan (CLK_FREQ_HZ=1000, TICK_HZ=100 → DIV=10):
- Pulse start_stop, run 250 cycles after the start edge, pulse start_stop → data_out 0x0025, running = 0; wait 100 cycles → still 0x0025; restart → the next increment arrives after the remaining prescaler count, not a full DIV.
- Preload by running to 0x0099 then one more tick → 0x0100; run to 0x0999, one more tick → 0x1000.
- At 0x0042 pulse lap → data_out stays 0x0042, lap_active = 1, while internal count advances. After 100 more cycles pulse start_stop → data_out shows the live count (about 0x0052), lap_active = 0.
- Run to 0x9999, one more tick:
  - Without the macro → 0x0000, overflow = 1, running = 1.
  - With LAP_TIMER_SATURATE_EN → 0x9999, overflow = 1, running = 0.
- In RUN, raise clear and start_stop in the same cycle → IDLE, data_out 0x0000, running = 0, overflow = 0. In STOP, pulse lap → IDLE, 0x0000.
- Drive reset low mid-run at count 0x0317 → all outputs 0 before the next clock edge. Release reset, pulse start_stop → counting from 0x0000; an input held high for 50 cycles yields one transition only.
